// File: rtl/countdown_timer_2hz.sv
// Countdown timer driven by a synchronized 2 Hz wave: counts a loaded M:SS value
// down to 0:00, then blinks an alarm for ALARM_SEC seconds. BCD outputs are registered.
module countdown_timer_2hz #(
    parameter int TICKS_PER_SEC = 2,
    parameter int ALARM_SEC     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_2HZ,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] load_min,
    input  logic [2:0] load_sec_t,
    input  logic [3:0] load_sec_o,
    output logic [3:0] min_bcd,
    output logic [2:0] sec_t,
    output logic [3:0] sec_o,
    output logic       running,
    output logic       done,
    output logic       alarm,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ALARM = 2'd3
    } state_e;

    localparam int SUB_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int ACNT_W = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [SUB_W-1:0]  SUB_ONE   = SUB_W'(1);
    localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(ALARM_SEC - 1);
    localparam logic [ACNT_W-1:0] ACNT_ONE  = ACNT_W'(1);

    logic s1_q, s2_q, s3_q, tick_q;

    state_e            state_q, state_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [ACNT_W-1:0] acnt_q, acnt_d;
    logic [3:0]        min_q, min_d;
    logic [2:0]        sect_q, sect_d;
    logic [3:0]        seco_q, seco_d;
    logic              done_q, done_d;
    logic              alarm_q, alarm_d;

    logic [3:0] ld_min, dec_min;
    logic [2:0] ld_sect, dec_sect;
    logic [3:0] ld_seco, dec_seco;
    logic       sub_counting, sec_strobe, time_zero, dec_zero;

    // clk_2HZ is asynchronous data: two flops resolve metastability, the third finds the edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            s1_q   <= clk_2HZ;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            tick_q <= s2_q & ~s3_q;
        end
    end

    assign ld_min  = (load_min   > 4'd9) ? 4'd9 : load_min;
    assign ld_sect = (load_sec_t > 3'd5) ? 3'd5 : load_sec_t;
    assign ld_seco = (load_sec_o > 4'd9) ? 4'd9 : load_sec_o;

    // One-second BCD decrement with borrow chain seconds-ones -> seconds-tens -> minutes.
    always_comb begin
        dec_min  = min_q;
        dec_sect = sect_q;
        dec_seco = seco_q - 4'd1;
        if (seco_q == 4'd0) begin
            dec_seco = 4'd9;
            dec_sect = sect_q - 3'd1;
            if (sect_q == 3'd0) begin
                dec_sect = 3'd5;
                dec_min  = min_q - 4'd1;
            end
        end
    end

    assign time_zero    = (min_q == 4'd0) && (sect_q == 3'd0) && (seco_q == 4'd0);
    assign dec_zero     = (dec_min == 4'd0) && (dec_sect == 3'd0) && (dec_seco == 4'd0);
    assign sub_counting = tick_q && ((state_q == S_RUN) || (state_q == S_ALARM));
    assign sec_strobe   = sub_counting && (sub_q == SUB_LAST);

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        acnt_d  = acnt_q;
        min_d   = min_q;
        sect_d  = sect_q;
        seco_d  = seco_q;
        done_d  = 1'b0;
        alarm_d = alarm_q;

        if (sub_counting) begin
            sub_d = sec_strobe ? '0 : sub_q + SUB_ONE;
        end

        unique case (state_q)
            S_IDLE: begin
                if (load) begin
                    {min_d, sect_d, seco_d} = {ld_min, ld_sect, ld_seco};
                end else if (start && !time_zero) begin
                    state_d = S_RUN;
                    sub_d   = '0;
                end
            end
            S_RUN: begin
                if (pause) begin
                    // A tick coincident with pause is dropped; sub keeps its phase.
                    state_d = S_PAUSE;
                    sub_d   = sub_q;
                end else if (sec_strobe) begin
                    {min_d, sect_d, seco_d} = {dec_min, dec_sect, dec_seco};
                    if (dec_zero) begin
                        state_d = S_ALARM;
                        done_d  = 1'b1;
                        alarm_d = 1'b1;
                        sub_d   = '0;
                        acnt_d  = '0;
                    end
                end
            end
            S_PAUSE: begin
                if (load) begin
                    {min_d, sect_d, seco_d} = {ld_min, ld_sect, ld_seco};
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_RUN;
                end
            end
            S_ALARM: begin
                if (load || start) begin
                    if (load) begin
                        {min_d, sect_d, seco_d} = {ld_min, ld_sect, ld_seco};
                    end
                    state_d = S_IDLE;
                    alarm_d = 1'b0;
                end else begin
                    if (tick_q) begin
                        alarm_d = ~alarm_q;
                    end
                    if (sec_strobe) begin
                        if (acnt_q == ACNT_LAST) begin
                            state_d = S_IDLE;
                            alarm_d = 1'b0;
                        end else begin
                            acnt_d = acnt_q + ACNT_ONE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sub_q   <= '0;
            acnt_q  <= '0;
            min_q   <= 4'd0;
            sect_q  <= 3'd0;
            seco_q  <= 4'd0;
            done_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            acnt_q  <= acnt_d;
            min_q   <= min_d;
            sect_q  <= sect_d;
            seco_q  <= seco_d;
            done_q  <= done_d;
            alarm_q <= alarm_d;
        end
    end

    assign min_bcd = min_q;
    assign sec_t   = sect_q;
    assign sec_o   = seco_q;
    assign running = (state_q == S_RUN);
    assign done    = done_q;
    assign alarm   = alarm_q;
    assign state   = state_q;

endmodule

// File: tb/tb_countdown_timer_2hz.sv
// Self-checking bench for countdown_timer_2hz: a table of operations with expected
// display/state pushed through a scoreboard, plus hand-written multi-cycle corner cases.
module tb_countdown_timer_2hz;

    typedef enum int {OP_LOAD, OP_START, OP_PAUSE, OP_EDGES} op_e;

    typedef struct {
        string       name;
        op_e         op;
        logic [3:0]  lm;
        logic [2:0]  lt;
        logic [3:0]  lo;
        int          n;
        logic [14:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [14:0] exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_2HZ = 1'b0;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] load_min = 4'd0;
    logic [2:0] load_sec_t = 3'd0;
    logic [3:0] load_sec_o = 4'd0;
    logic [3:0] min_bcd;
    logic [2:0] sec_t;
    logic [3:0] sec_o;
    logic       running, done, alarm;
    logic [1:0] state;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    countdown_timer_2hz #(.TICKS_PER_SEC(2), .ALARM_SEC(3)) dut (
        .clk(clk), .rst(rst), .clk_2HZ(clk_2HZ),
        .load(load), .start(start), .pause(pause),
        .load_min(load_min), .load_sec_t(load_sec_t), .load_sec_o(load_sec_o),
        .min_bcd(min_bcd), .sec_t(sec_t), .sec_o(sec_o),
        .running(running), .done(done), .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observed vector: {min, sec_t, sec_o, state, alarm, running}.
    function automatic logic [14:0] obs();
        return {min_bcd, sec_t, sec_o, state, alarm, running};
    endfunction

    function automatic logic [14:0] mk(input logic [3:0] m, input logic [2:0] t,
                                       input logic [3:0] o, input logic [1:0] s, input logic a);
        return {m, t, o, s, a, (s == 2'd1)};
    endfunction

    function automatic void add(input string name, input op_e op, input logic [3:0] lm,
                                input logic [2:0] lt, input logic [3:0] lo, input int n,
                                input logic [14:0] exp);
        vec_t v;
        v.name = name; v.op = op; v.lm = lm; v.lt = lt; v.lo = lo; v.n = n; v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] m, input logic [2:0] t, input logic [3:0] o);
        load = 1'b1; load_min = m; load_sec_t = t; load_sec_o = o;
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        step();
        pause = 1'b0;
    endtask

    // One full 2 Hz period; the display settles 4 clk cycles after the rise.
    task automatic edges(input int n);
        for (int k = 0; k < n; k++) begin
            clk_2HZ = 1'b1;
            repeat (6) step();
            clk_2HZ = 1'b0;
            repeat (4) step();
        end
    endtask

    initial begin
        int   bad;
        int   lat;
        int   dcnt;
        logic [14:0] at_done;
        sb_t  e;

        // Reset with clk_2HZ high, then 100 idle cycles including the spurious tick.
        clk_2HZ = 1'b1;
        rst = 1'b1;
        repeat (4) step();
        check("reset_outputs", {17'd0, obs()}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (obs() !== 15'd0 || done !== 1'b0) bad++;
        end
        check("idle_hold_100", bad, 0);
        clk_2HZ = 1'b0;
        repeat (4) step();

        // Tick latency: 3 cycles to tick, display one cycle later.
        do_load(4'd0, 3'd0, 4'd2);
        do_start();
        edges(1);
        clk_2HZ = 1'b1;
        lat = 99;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (sec_o == 4'd1) begin
                lat = c;
                break;
            end
        end
        check("tick_latency", lat, 4);
        clk_2HZ = 1'b0;
        repeat (4) step();
        do_pause();
        do_load(4'd0, 3'd0, 4'd0);

        // Operation table: short countdown, alarm expiry, clamp, borrow chain, pause/resume.
        add("load_003",   OP_LOAD,  4'd0, 3'd0, 4'd3,  0, mk(4'd0, 3'd0, 4'd3, 2'd0, 1'b0));
        add("start_003",  OP_START, 4'd0, 3'd0, 4'd0,  0, mk(4'd0, 3'd0, 4'd3, 2'd1, 1'b0));
        add("half_sec",   OP_EDGES, 4'd0, 3'd0, 4'd0,  1, mk(4'd0, 3'd0, 4'd3, 2'd1, 1'b0));
        add("cd_002",     OP_EDGES, 4'd0, 3'd0, 4'd0,  1, mk(4'd0, 3'd0, 4'd2, 2'd1, 1'b0));
        add("cd_001",     OP_EDGES, 4'd0, 3'd0, 4'd0,  2, mk(4'd0, 3'd0, 4'd1, 2'd1, 1'b0));
        add("cd_000",     OP_EDGES, 4'd0, 3'd0, 4'd0,  2, mk(4'd0, 3'd0, 4'd0, 2'd3, 1'b1));
        add("alarm_e1",   OP_EDGES, 4'd0, 3'd0, 4'd0,  1, mk(4'd0, 3'd0, 4'd0, 2'd3, 1'b0));
        add("alarm_e2",   OP_EDGES, 4'd0, 3'd0, 4'd0,  1, mk(4'd0, 3'd0, 4'd0, 2'd3, 1'b1));
        add("alarm_e3",   OP_EDGES, 4'd0, 3'd0, 4'd0,  1, mk(4'd0, 3'd0, 4'd0, 2'd3, 1'b0));
        add("alarm_e4",   OP_EDGES, 4'd0, 3'd0, 4'd0,  1, mk(4'd0, 3'd0, 4'd0, 2'd3, 1'b1));
        add("alarm_e5",   OP_EDGES, 4'd0, 3'd0, 4'd0,  1, mk(4'd0, 3'd0, 4'd0, 2'd3, 1'b0));
        add("alarm_end",  OP_EDGES, 4'd0, 3'd0, 4'd0,  1, mk(4'd0, 3'd0, 4'd0, 2'd0, 1'b0));
        add("clamp_059",  OP_LOAD,  4'd0, 3'd7, 4'd12, 0, mk(4'd0, 3'd5, 4'd9, 2'd0, 1'b0));
        add("load_100",   OP_LOAD,  4'd1, 3'd0, 4'd0,  0, mk(4'd1, 3'd0, 4'd0, 2'd0, 1'b0));
        add("start_100",  OP_START, 4'd0, 3'd0, 4'd0,  0, mk(4'd1, 3'd0, 4'd0, 2'd1, 1'b0));
        add("borrow_059", OP_EDGES, 4'd0, 3'd0, 4'd0,  2, mk(4'd0, 3'd5, 4'd9, 2'd1, 1'b0));
        add("load_in_run",OP_LOAD,  4'd3, 3'd3, 4'd3,  0, mk(4'd0, 3'd5, 4'd9, 2'd1, 1'b0));
        add("pause_059",  OP_PAUSE, 4'd0, 3'd0, 4'd0,  0, mk(4'd0, 3'd5, 4'd9, 2'd2, 1'b0));
        add("load_210",   OP_LOAD,  4'd2, 3'd1, 4'd0,  0, mk(4'd2, 3'd1, 4'd0, 2'd0, 1'b0));
        add("start_210",  OP_START, 4'd0, 3'd0, 4'd0,  0, mk(4'd2, 3'd1, 4'd0, 2'd1, 1'b0));
        add("borrow_209", OP_EDGES, 4'd0, 3'd0, 4'd0,  2, mk(4'd2, 3'd0, 4'd9, 2'd1, 1'b0));
        add("pause_209",  OP_PAUSE, 4'd0, 3'd0, 4'd0,  0, mk(4'd2, 3'd0, 4'd9, 2'd2, 1'b0));
        add("load_005",   OP_LOAD,  4'd0, 3'd0, 4'd5,  0, mk(4'd0, 3'd0, 4'd5, 2'd0, 1'b0));
        add("start_005",  OP_START, 4'd0, 3'd0, 4'd0,  0, mk(4'd0, 3'd0, 4'd5, 2'd1, 1'b0));
        add("run_1edge",  OP_EDGES, 4'd0, 3'd0, 4'd0,  1, mk(4'd0, 3'd0, 4'd5, 2'd1, 1'b0));
        add("pause_005",  OP_PAUSE, 4'd0, 3'd0, 4'd0,  0, mk(4'd0, 3'd0, 4'd5, 2'd2, 1'b0));
        add("pause_hold", OP_EDGES, 4'd0, 3'd0, 4'd0, 10, mk(4'd0, 3'd0, 4'd5, 2'd2, 1'b0));
        add("resume",     OP_START, 4'd0, 3'd0, 4'd0,  0, mk(4'd0, 3'd0, 4'd5, 2'd1, 1'b0));
        add("resume_dec", OP_EDGES, 4'd0, 3'd0, 4'd0,  1, mk(4'd0, 3'd0, 4'd4, 2'd1, 1'b0));
        add("pause_004",  OP_PAUSE, 4'd0, 3'd0, 4'd0,  0, mk(4'd0, 3'd0, 4'd4, 2'd2, 1'b0));
        add("load_000",   OP_LOAD,  4'd0, 3'd0, 4'd0,  0, mk(4'd0, 3'd0, 4'd0, 2'd0, 1'b0));
        add("start_zero", OP_START, 4'd0, 3'd0, 4'd0,  0, mk(4'd0, 3'd0, 4'd0, 2'd0, 1'b0));
        add("clamp_959",  OP_LOAD,  4'd15,3'd6, 4'd10, 0, mk(4'd9, 3'd5, 4'd9, 2'd0, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_LOAD:  do_load(vecs[i].lm, vecs[i].lt, vecs[i].lo);
                OP_START: do_start();
                OP_PAUSE: do_pause();
                default:  edges(vecs[i].n);
            endcase
            sb.push_back('{vecs[i].name, vecs[i].exp});
            e = sb.pop_front();
            check(e.name, {17'd0, obs()}, {17'd0, e.exp});
        end

        // load beats start in IDLE.
        load = 1'b1; start = 1'b1;
        load_min = 4'd0; load_sec_t = 3'd0; load_sec_o = 4'd7;
        step();
        load = 1'b0; start = 1'b0;
        check("load_start_idle", {17'd0, obs()}, {17'd0, mk(4'd0, 3'd0, 4'd7, 2'd0, 1'b0)});

        // done is one cycle wide and coincides with 0:00 in ALARM.
        do_load(4'd0, 3'd0, 4'd1);
        do_start();
        edges(1);
        clk_2HZ = 1'b1;
        dcnt = 0;
        at_done = '0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (done === 1'b1) begin
                dcnt++;
                at_done = obs();
            end
        end
        clk_2HZ = 1'b0;
        repeat (4) step();
        check("done_width", dcnt, 1);
        check("done_display", {17'd0, at_done}, {17'd0, mk(4'd0, 3'd0, 4'd0, 2'd3, 1'b1)});

        // load acknowledges ALARM and applies the new value.
        do_load(4'd4, 3'd3, 4'd2);
        check("alarm_load_ack", {17'd0, obs()}, {17'd0, mk(4'd4, 3'd3, 4'd2, 2'd0, 1'b0)});

        // start acknowledges ALARM mid-blink.
        do_load(4'd0, 3'd0, 4'd1);
        do_start();
        edges(2);
        edges(1);
        do_start();
        check("alarm_start_ack", {17'd0, obs()}, {17'd0, mk(4'd0, 3'd0, 4'd0, 2'd0, 1'b0)});

        // pause coincident with sec_strobe drops the decrement.
        do_load(4'd0, 3'd0, 4'd3);
        do_start();
        edges(1);
        clk_2HZ = 1'b1;
        repeat (3) step();
        do_pause();
        check("pause_vs_strobe", {17'd0, obs()}, {17'd0, mk(4'd0, 3'd0, 4'd3, 2'd2, 1'b0)});
        clk_2HZ = 1'b0;
        repeat (4) step();
        edges(2);
        check("pause_hold_2", {17'd0, obs()}, {17'd0, mk(4'd0, 3'd0, 4'd3, 2'd2, 1'b0)});

        // rst at the final strobe aborts without a done pulse.
        do_load(4'd0, 3'd0, 4'd1);
        do_start();
        edges(1);
        clk_2HZ = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (done === 1'b1) dcnt++;
        end
        rst = 1'b0;
        clk_2HZ = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (done === 1'b1) dcnt++;
        end
        check("rst_no_done", dcnt, 0);
        check("rst_state", {17'd0, obs()}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
